// File: rtl/ram_bus_adapter_if.sv
// Bus-side handshake of the RAM bus adapter: request/write channel from the
// master, accept/read-response channel back from the adapter.
interface ram_bus_adapter_if #(
    parameter int dat_width = 32,
    parameter int adr_width = 32
);
    logic                   req_i;
    logic                   we_i;
    logic [adr_width-1:0]   addr_i;
    logic [dat_width/8-1:0] be_i;
    logic [dat_width-1:0]   wdata_i;
    logic                   ack_o;
    logic                   resp_o;
    logic [dat_width-1:0]   rdata_o;

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i,
        input  ack_o, resp_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i,
        output ack_o, resp_o, rdata_o
    );
endinterface

// File: rtl/ram_bus_adapter.sv
// Byte-addressed request bus to single-port word RAM adapter; partial writes
// are done as a read-modify-write over two cycles.
//
// state   | meaning
// IDLE    | no read outstanding, ready for a request
// RD_RESP | read data from RAM is valid this cycle, ready for a request
// RMW_WR  | merging latched write bytes into the word read last cycle
module ram_bus_adapter #(
    parameter int dat_width = 32,
    parameter int adr_width = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_bus_adapter_if.slave     bus,
    output logic [adr_width-1:0] ram_adr_o,
    output logic                 ram_we_o,
    output logic [dat_width-1:0] ram_dat_o,
    input  logic [dat_width-1:0] ram_dat_i
);
    localparam int be_width = dat_width / 8;
    localparam int off_bits = $clog2(be_width);

    typedef enum logic [1:0] {IDLE, RD_RESP, RMW_WR} state_t;

    state_t               state_q, state_d;
    logic [adr_width-1:0] adr_q, adr_d;
    logic [be_width-1:0]  be_q, be_d;
    logic [dat_width-1:0] wdata_q, wdata_d;

    logic                 accept;
    logic                 full_wr;
    logic                 part_wr;
    logic [adr_width-1:0] word_adr;
    logic [dat_width-1:0] merged;

    assign word_adr    = bus.addr_i >> off_bits;
    assign accept      = bus.req_i && !rst && (state_q != RMW_WR);
    assign full_wr     = bus.we_i && (bus.be_i == '1);
    assign part_wr     = bus.we_i && (bus.be_i != '0) && !full_wr;
    assign bus.ack_o   = accept;
    assign bus.resp_o  = (state_q == RD_RESP);
    assign bus.rdata_o = bus.resp_o ? ram_dat_i : '0;

    // Bytes not enabled keep the value the RAM returned for the first cycle's read.
    always_comb begin
        merged = ram_dat_i;
        for (int k = 0; k < be_width; k++) begin
            if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
        end
    end

    always_comb begin
        state_d   = IDLE;
        adr_d     = adr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        ram_adr_o = '0;
        ram_we_o  = 1'b0;
        ram_dat_o = '0;
        if (state_q == RMW_WR) begin
            // A reset here drops the merge so the RAM word stays untouched.
            if (!rst) begin
                ram_adr_o = adr_q;
                ram_we_o  = 1'b1;
                ram_dat_o = merged;
            end
        end else if (accept) begin
            ram_adr_o = word_adr;
            if (!bus.we_i) begin
                state_d = RD_RESP;
            end else if (full_wr) begin
                ram_we_o  = 1'b1;
                ram_dat_o = bus.wdata_i;
            end else if (part_wr) begin
                state_d = RMW_WR;
                adr_d   = word_adr;
                be_d    = bus.be_i;
                wdata_d = bus.wdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end
endmodule
